serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to begin one addition; sampled on rising edge.
REQ-005 SHALL have port: a  input  WIDTH  operand A; sampled only on the edge that accepts start.
REQ-006 SHALL have port: b  input  WIDTH  operand B; sampled only on the edge that accepts start.
REQ-007 SHALL have port: c_in  input  1  carry-in; sampled only on the edge that accepts start.
REQ-008 SHALL have port: busy  output  1  high while an addition is in progress (state ADD).
REQ-009 SHALL have port: done  output  1  one-cycle pulse; sum/c_out valid.
REQ-010 SHALL have port: sum  output  WIDTH  registered result (a+b+c_in) mod 2^WIDTH.
REQ-011 SHALL have port: c_out  output  1  registered carry-out of the addition.

Function
REQ-012 SHALL use exactly one 1-bit full-add (sum = x^y^c, carry = majority(x,y,c)), time-shared over all bit positions LSB first.
REQ-013 SHALL implement FSM states IDLE, ADD, DONE; all outputs registered or decoded from state only.
REQ-014 IDLE: start=1 at an edge SHALL load shift regs A<=a, B<=b, carry reg<=c_in, bit counter<=0, next state ADD; start=0 stays IDLE.
REQ-015 ADD: each edge SHALL apply full-add to A[0], B[0], carry reg; shift result bit into internal result shift reg MSB; shift A, B right by 1; carry reg<=full-add carry; counter+1.
REQ-016 ADD SHALL last exactly WIDTH cycles; on the edge where counter==WIDTH-1, SHALL transfer the completed result into sum and final carry into c_out, next state DONE.
REQ-017 DONE: done=1 for exactly that one cycle; next edge SHALL return to IDLE unconditionally.
REQ-018 Latency: start accepted at edge T -> busy high cycles T+1..T+WIDTH, done high in cycle T+WIDTH+1; throughput one addition per WIDTH+2 cycles.
REQ-019 start in ADD or DONE SHALL be ignored (no reload, no queuing); operands changing during ADD SHALL not affect the result.
REQ-020 sum and c_out SHALL hold their last value in IDLE/ADD until the next transition into DONE.
REQ-021 busy and done SHALL never be high in the same cycle.
REQ-022 Counter width SHALL be clog2(WIDTH) bits minimum; no wrap-around shall occur before the DONE transition.

Reset
REQ-023 rst=1 at an edge SHALL force state IDLE, busy=0, done=0, sum=0, c_out=0, counter=0, shift and carry regs=0; rst has priority over start.
REQ-024 rst asserted during ADD or DONE SHALL abort the addition with no done pulse; sum/c_out read 0 afterwards.
REQ-025 After rst deasserts, a start on the first subsequent edge SHALL be accepted normally.

Verification (WIDTH=8)
REQ-026 a=0x5A, b=0x33, c_in=0, start one cycle -> busy 8 cycles, done in cycle T+9, sum=0x8D, c_out=0.
REQ-027 a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1; a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, c_out=1.
REQ-028 start held high continuously with a=0x10, b=0x20 -> results every 10 cycles, sum=0x30; operands changed to 0x01/0x01 mid-ADD -> current result still 0x30.
REQ-029 rst pulsed at third ADD cycle of 0x5A+0x33 -> no done pulse, busy=0 next cycle, sum=0x00, c_out=0; next start 0x01+0x02 -> sum=0x03.
REQ-030 rst and start high on same edge -> remains IDLE, busy=0; exhaustive random a/b/c_in (>=1000 ops) -> sum/c_out match (a+b+c_in) reference model.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-add cell time-shared over WIDTH bit positions, LSB first.
// Latency: start accepted at edge T -> busy for WIDTH cycles, done pulses WIDTH+1 cycles after T.
// Backpressure: none; start is ignored while busy or done, with no queuing.
//
// Ports:
//   clk, rst      - single clock, synchronous active-high reset
//   start         - begin one addition (accepted only in IDLE)
//   a, b, c_in    - operands and carry-in, captured on the accepting edge only
//   busy          - high while bits are being added (state ADD)
//   done          - one-cycle pulse when sum/c_out have just been updated
//   sum, c_out    - registered result, held until the next completion
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    // Counter only has to reach WIDTH-1; it is cleared on the last edge,
    // so it never wraps while an addition is still running.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Only the upper WIDTH-1 result bits need storage: the bit produced on
    // the last ADD edge goes straight into sum alongside them.
    logic [WIDTH-2:0] res_sh;
    logic             carry;
    logic [CW-1:0]    bit_cnt;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] res_next;

    // The single full-add cell.
    assign fa_sum   = a_sh[0] ^ b_sh[0] ^ carry;
    assign fa_carry = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

    // New bit enters at the MSB; after WIDTH shifts bit 0 of the result sits at the LSB.
    assign res_next = {fa_sum, res_sh};

    // Status outputs are pure state decodes, so busy and done are exclusive by construction.
    assign busy = (state == S_ADD);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
            sum     <= '0;
            c_out   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry   <= c_in;
                        res_sh  <= '0;
                        bit_cnt <= '0;
                        state   <= S_ADD;
                    end
                end

                S_ADD: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_carry;
                    res_sh <= res_next[WIDTH-1:1];
                    if (bit_cnt == LAST_BIT) begin
                        sum     <= res_next;
                        c_out   <= fa_carry;
                        bit_cnt <= '0;
                        state   <= S_DONE;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8) using a result scoreboard.
// Expected {c_out,sum} values are queued when an addition is requested and
// compared whenever the DUT pulses done.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [W:0] exp_q[$];
    int         done_cycs[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: outputs sampled on the falling edge.
    always @(negedge clk) begin
        if (busy && done)
            check("busy_done_excl", 32'(busy & done), 32'd0);
        if (done) begin
            done_cycs.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("result", 32'({c_out, sum}), 32'(e));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // One start pulse; operands are scrambled right after acceptance so any
    // late sampling of a/b/c_in shows up as a wrong result.
    task automatic do_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
        wait_idle();
        a     = av;
        b     = bv;
        c_in  = ci;
        start = 1'b1;
        exp_q.push_back({1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci});
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom_range(255));
        b     = W'($urandom_range(255));
        c_in  = 1'($urandom_range(1));
    endtask

    initial begin
        int t_req;
        int busy_cnt;
        int done_at;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_sum",   32'(sum),   32'd0);
        check("rst_c_out", 32'(c_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Latency / busy length for 0x5A + 0x33.
        t_req = cyc;
        a = 8'h5A; b = 8'h33; c_in = 1'b0; start = 1'b1;
        exp_q.push_back(9'h08D);
        @(negedge clk);
        start = 1'b0; a = 8'hFF; b = 8'hFF; c_in = 1'b1;
        busy_cnt = (busy ? 1 : 0);
        done_at  = -1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done && done_at < 0) done_at = cyc;
        end
        check("busy_cycles", 32'(busy_cnt), 32'd8);
        check("done_latency", 32'(done_at - t_req), 32'd9);
        drain();

        // Carry boundary cases.
        do_add(8'hFF, 8'h01, 1'b0);
        do_add(8'hFF, 8'hFF, 1'b1);
        do_add(8'h00, 8'h00, 1'b0);
        drain();

        // start held high: back-to-back results every WIDTH+2 cycles; operands
        // change during the third addition and must not affect it.
        wait_idle();
        done_cycs.delete();
        a = 8'h10; b = 8'h20; c_in = 1'b0; start = 1'b1;
        repeat (3) exp_q.push_back(9'h030);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 24) begin a = 8'h01; b = 8'h01; end
            if (k == 25) start = 1'b0;
        end
        check("held_done_count", 32'(done_cycs.size()), 32'd3);
        if (done_cycs.size() == 3) begin
            check("held_period_1", 32'(done_cycs[1] - done_cycs[0]), 32'd10);
            check("held_period_2", 32'(done_cycs[2] - done_cycs[1]), 32'd10);
        end
        check("held_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset during the third ADD cycle aborts with no done pulse.
        wait_idle();
        a = 8'h5A; b = 8'h33; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy",  32'(busy),  32'd0);
        check("abort_done",  32'(done),  32'd0);
        check("abort_sum",   32'(sum),   32'd0);
        check("abort_c_out", 32'(c_out), 32'd0);
        rst = 1'b0;
        do_add(8'h01, 8'h02, 1'b0);
        drain();

        // rst wins over start on the same edge.
        wait_idle();
        @(negedge clk);
        rst = 1'b1; start = 1'b1; a = 8'h77; b = 8'h11; c_in = 1'b1;
        @(negedge clk);
        check("rst_start_busy", 32'(busy), 32'd0);
        check("rst_start_sum",  32'(sum),  32'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_start_idle", 32'(busy), 32'd0);

        // Random operands against the reference sum.
        for (int i = 0; i < 1000; i++)
            do_add(W'($urandom_range(255)), W'($urandom_range(255)), 1'($urandom_range(1)));
        drain();
        repeat (3) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
